// File: rtl/cluster_pass_sequencer_pkg.sv
// cluster_pass_sequencer_pkg: cluster word constants and the sequencer state encoding.
// The state encoding is shared with the downstream cluster packer.
package cluster_pass_sequencer_pkg;
    localparam int CLUSTER_W = 14;
    localparam logic [10:0] INVALID_ADR = 11'h7FF;
    localparam logic [CLUSTER_W-1:0] INVALID_CLUSTER = {3'd0, INVALID_ADR};
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } seq_state_e;
endpackage

// File: rtl/cluster_pass_sequencer_slot_bank.sv
// cluster_pass_sequencer_slot_bank: pending cluster slots with indexed write, clear-all and publish.
// The published copy holds until the next publish.
module cluster_pass_sequencer_slot_bank
    import cluster_pass_sequencer_pkg::*;
#(
    parameter int MXCLUSTERS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear_i,
    input  logic                            wr_i,
    input  logic [2:0]                      idx_i,
    input  logic [CLUSTER_W-1:0]            data_i,
    input  logic                            publish_i,
    output logic [MXCLUSTERS*CLUSTER_W-1:0] clusters_o
);
    localparam logic [MXCLUSTERS*CLUSTER_W-1:0] ALL_INVALID = {MXCLUSTERS{INVALID_CLUSTER}};

    logic [MXCLUSTERS*CLUSTER_W-1:0] pend_q, pend_d, out_q;

    // A new frame's clear wins over a write from the pass it aborts
    always_comb begin
        pend_d = pend_q;
        if (wr_i) pend_d[int'(idx_i)*CLUSTER_W +: CLUSTER_W] = data_i;
        if (clear_i) pend_d = ALL_INVALID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= ALL_INVALID;
            out_q  <= ALL_INVALID;
        end else begin
            pend_q <= pend_d;
            if (publish_i) out_q <= pend_q;
        end
    end

    assign clusters_o = out_q;
endmodule

// File: rtl/cluster_pass_sequencer.sv
// cluster_pass_sequencer: runs the pad priority encoder over up to MXCLUSTERS passes per frame.
// Optional macro PASS_CHECK_EN: check the encoder's echoed pass tag and end the frame on mismatch.
module cluster_pass_sequencer
    import cluster_pass_sequencer_pkg::*;
#(
    parameter int MXPADS     = 768,
    parameter int MXCLUSTERS = 8,
    parameter int ENC_LAT    = 3,
    parameter int ADRB       = 11
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            frame_start_i,
    input  logic [MXPADS-1:0]               vpfs_i,
    output logic                            enc_latch_pulse_o,
    output logic [MXPADS-1:0]               enc_vpfs_o,
    output logic [2:0]                      enc_pass_o,
    input  logic                            enc_cluster_found_i,
    input  logic [ADRB-1:0]                 enc_adr_i,
    input  logic [2:0]                      enc_cnt_i,
    input  logic [2:0]                      enc_pass_out_i,
    output logic [MXCLUSTERS*CLUSTER_W-1:0] clusters_o,
    output logic                            clusters_valid_o,
    output logic                            busy_o,
    output logic                            frame_overrun_o,
    output logic                            pass_err_o
);
    localparam int CW = (ENC_LAT > 1) ? $clog2(ENC_LAT) : 1;
    localparam logic [2:0] LAST_PASS = 3'(MXCLUSTERS - 1);
    localparam logic [MXPADS-1:0] ONE = {{(MXPADS-1){1'b0}}, 1'b1};

    seq_state_e state_q, state_d;
    logic [MXPADS-1:0] work_q, work_d;
    logic [2:0] pass_q, pass_d, epass_q, epass_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic latch_q, latch_d, busy_q, busy_d, valid_q, valid_d, ovr_q, ovr_d, perr_q, perr_d;
    logic clear, wr, publish, pass_bad;

`ifdef PASS_CHECK_EN
    assign pass_bad = enc_pass_out_i != pass_q;
`else
    logic unused_pass_out;
    assign unused_pass_out = ^enc_pass_out_i;
    assign pass_bad = 1'b0;
`endif

    // The working mask doubles as the encoder input, so it only moves between passes
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        pass_d  = pass_q;
        epass_d = epass_q;
        wcnt_d  = wcnt_q;
        busy_d  = busy_q;
        ovr_d   = ovr_q;
        perr_d  = perr_q;
        latch_d = 1'b0;
        valid_d = 1'b0;
        clear   = 1'b0;
        wr      = 1'b0;
        publish = 1'b0;
        case (state_q)
            S_ISSUE: begin
                epass_d = pass_q;
                wcnt_d  = CW'(ENC_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                wcnt_d  = wcnt_q - CW'(1);
                state_d = (wcnt_q == '0) ? S_CAPTURE : S_WAIT;
            end
            S_CAPTURE: begin
                if (pass_bad) begin
                    perr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (!enc_cluster_found_i) begin
                    state_d = S_DONE;
                end else begin
                    wr      = 1'b1;
                    // Shifting past the top bit yields zero, so out-of-range addresses clear nothing
                    work_d  = work_q & ~(ONE << enc_adr_i);
                    pass_d  = pass_q + 3'd1;
                    state_d = (pass_q == LAST_PASS) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                publish = 1'b1;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: ;
        endcase
        if (frame_start_i) begin
            ovr_d   = ovr_q | (state_q != S_IDLE && state_q != S_DONE);
            work_d  = vpfs_i;
            pass_d  = '0;
            busy_d  = 1'b1;
            latch_d = 1'b1;
            clear   = 1'b1;
            state_d = S_ISSUE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            pass_q  <= '0;
            epass_q <= '0;
            wcnt_q  <= '0;
            latch_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            pass_q  <= pass_d;
            epass_q <= epass_d;
            wcnt_q  <= wcnt_d;
            latch_q <= latch_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            perr_q  <= perr_d;
        end
    end

    cluster_pass_sequencer_slot_bank #(.MXCLUSTERS(MXCLUSTERS)) u_slots (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .wr_i       (wr),
        .idx_i      (pass_q),
        .data_i     ({enc_cnt_i, enc_adr_i}),
        .publish_i  (publish),
        .clusters_o (clusters_o)
    );

    assign enc_latch_pulse_o = latch_q;
    assign enc_vpfs_o        = work_q;
    assign enc_pass_o        = epass_q;
    assign clusters_valid_o  = valid_q;
    assign busy_o            = busy_q;
    assign frame_overrun_o   = ovr_q;
    assign pass_err_o        = perr_q;
endmodule

// File: tb/tb_cluster_pass_sequencer.sv
// tb_cluster_pass_sequencer: randomized frames checked against a cluster-list reference model,
// with a lowest-pad-first encoder model of fixed latency driving the encoder inputs.
`timescale 1ns/1ps
module tb_cluster_pass_sequencer;
    import cluster_pass_sequencer_pkg::*;
    localparam int NP = 768;
    localparam int NC = 8;
    localparam int LAT = 3;
    localparam int SW = NC * 14;
    localparam logic [SW-1:0] ALL_INV = {NC{INVALID_CLUSTER}};

    logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
    logic [NP-1:0] vpfs_in = '0;
    logic enc_latch_pulse, enc_found;
    logic [NP-1:0] enc_vpfs;
    logic [2:0] enc_pass, enc_cnt, enc_pass_echo;
    logic [10:0] enc_adr;
    logic [SW-1:0] clusters;
    logic clusters_valid, busy, frame_overrun, pass_err;
    logic bad_adr = 1'b0, corrupt = 1'b0;
    logic [NP-1:0] v0 = '0, v1 = '0, v2 = '0;
    logic [2:0] p0 = '0, p1 = '0, p2 = '0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    cluster_pass_sequencer dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .frame_start_i       (frame_start),
        .vpfs_i              (vpfs_in),
        .enc_latch_pulse_o   (enc_latch_pulse),
        .enc_vpfs_o          (enc_vpfs),
        .enc_pass_o          (enc_pass),
        .enc_cluster_found_i (enc_found),
        .enc_adr_i           (enc_adr),
        .enc_cnt_i           (enc_cnt),
        .enc_pass_out_i      (enc_pass_echo),
        .clusters_o          (clusters),
        .clusters_valid_o    (clusters_valid),
        .busy_o              (busy),
        .frame_overrun_o     (frame_overrun),
        .pass_err_o          (pass_err)
    );

    function automatic logic [2:0] cnt_of(input logic [10:0] a);
        return ~a[2:0];
    endfunction

    // Encoder model: LAT-stage delay, then lowest set pad wins
    always @(posedge clk) begin
        v0 <= enc_vpfs; v1 <= v0; v2 <= v1;
        p0 <= enc_pass; p1 <= p0; p2 <= p1;
    end

    always_comb begin
        enc_found = 1'b0;
        enc_adr = 11'h7FF;
        for (int i = NP - 1; i >= 0; i--) if (v2[i]) begin enc_found = 1'b1; enc_adr = 11'(i); end
        if (bad_adr) begin enc_found = 1'b1; enc_adr = 11'h7F0; end
        enc_cnt = enc_found ? cnt_of(enc_adr) : 3'd0;
        enc_pass_echo = (corrupt && p2 == 3'd1) ? 3'd5 : p2;
    end

    // Reference: up to NC lowest pads in ascending order; one extra pass discovers emptiness
    function automatic void model(input logic [NP-1:0] v, output logic [SW-1:0] s,
                                  output int lat, output logic [NP-1:0] left);
        int k;
        k = 0;
        s = ALL_INV;
        left = v;
        for (int i = 0; i < NP && k < NC; i++) if (v[i]) begin
            s[k*14 +: 14] = {cnt_of(11'(i)), 11'(i)};
            left[i] = 1'b0;
            k++;
        end
        lat = 2 + (LAT + 2) * ((k < NC) ? k + 1 : NC);
    endfunction

    function automatic logic [NP-1:0] rand_mask(input int k);
        logic [NP-1:0] v;
        v = '0;
        repeat (k) v[$urandom_range(0, NP - 1)] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [NP-1:0] v);
        vpfs_in = v;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        vpfs_in = '0;
    endtask

    task automatic check_frame(input string nm, input logic [SW-1:0] es, input int elat,
                               input logic [NP-1:0] eleft, input int n0);
        int n;
        n = n0;
        while (clusters_valid !== 1'b1 && n < 200) begin step(); n++; end
        total++;
        if (n != elat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, n, elat); end
        total++;
        if (clusters !== es) begin bad++; $display("FAIL %s clusters got=%h want=%h", nm, clusters, es); end
        total++;
        if (enc_vpfs !== eleft) begin bad++; $display("FAIL %s work got=%h want=%h", nm, enc_vpfs, eleft); end
        step();
        total++;
        if (clusters_valid !== 1'b0 || busy !== 1'b0 || clusters !== es) begin
            bad++;
            $display("FAIL %s pulse/hold got valid=%b busy=%b clusters=%h want 0 0 %h", nm, clusters_valid, busy, clusters, es);
        end
    endtask

    task automatic expect_frame(input string nm, input logic [NP-1:0] v, input int n0);
        logic [SW-1:0] s;
        logic [NP-1:0] left;
        int lat;
        model(v, s, lat, left);
        check_frame(nm, s, lat, left, n0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        total++;
        if (clusters !== ALL_INV) begin bad++; $display("FAIL reset clusters got=%h want=%h", clusters, ALL_INV); end
        total++;
        if (enc_vpfs !== '0 || enc_pass !== 3'd0) begin bad++; $display("FAIL reset enc got pass=%0d vpfs_nz=%b want 0 0", enc_pass, |enc_vpfs); end
        total++;
        if ({busy, clusters_valid, enc_latch_pulse, frame_overrun, pass_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset flags got=%b want=00000", {busy, clusters_valid, enc_latch_pulse, frame_overrun, pass_err});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        logic [NP-1:0] v;
        logic [SW-1:0] s;
        v = '0;
        v[37] = 1'b1;
        s = ALL_INV;
        s[13:0] = {3'd2, 11'd37};
        start(v);
        total++;
        if (enc_latch_pulse !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single latch/busy got=%b%b want=11", enc_latch_pulse, busy); end
        step();
        total++;
        if (enc_latch_pulse !== 1'b0) begin bad++; $display("FAIL single latch width got=%b want=0", enc_latch_pulse); end
        check_frame("single", s, 2 + 2 * (LAT + 2), '0, 2);
    endtask

    task automatic test_three();
        logic [NP-1:0] v, left;
        int pads [3] = '{5, 100, 767};
        v = '0;
        foreach (pads[i]) v[pads[i]] = 1'b1;
        left = v;
        start(v);
        foreach (pads[i]) begin
            repeat (LAT + 2) step();
            left[pads[i]] = 1'b0;
            total++;
            if (enc_vpfs !== left) begin bad++; $display("FAIL three clear pass %0d got=%h want=%h", i, enc_vpfs, left); end
        end
        expect_frame("three", v, 1 + 3 * (LAT + 2));
    endtask

    task automatic test_ten();
        logic [NP-1:0] v;
        int pads [10] = '{3, 50, 51, 200, 300, 400, 500, 600, 700, 766};
        v = '0;
        foreach (pads[i]) v[pads[i]] = 1'b1;
        start(v);
        expect_frame("ten", v, 1);
        total++;
        if (frame_overrun !== 1'b0 || pass_err !== 1'b0) begin bad++; $display("FAIL ten flags got=%b%b want=00", frame_overrun, pass_err); end
    endtask

    task automatic test_empty();
        start('0);
        check_frame("empty", ALL_INV, 2 + (LAT + 2), '0, 1);
    endtask

    task automatic test_random();
        logic [NP-1:0] v;
        for (int f = 0; f < 8; f++) begin
            v = rand_mask($urandom_range(0, 12));
            if (f == 3) v[NP-1] = 1'b1;
            start(v);
            expect_frame("random", v, 1);
            repeat ($urandom_range(0, 3)) step();
        end
    endtask

    task automatic test_back_to_back();
        logic [NP-1:0] va, vb, la;
        logic [SW-1:0] sa;
        int lat, n;
        logic early;
        va = rand_mask(2);
        vb = rand_mask(3);
        model(va, sa, lat, la);
        start(va);
        n = 1;
        early = 1'b0;
        while (n < lat - 1) begin step(); n++; early |= clusters_valid; end
        start(vb);
        total++;
        if (early || clusters_valid !== 1'b1 || clusters !== sa) begin
            bad++;
            $display("FAIL b2b publish got early=%b valid=%b clusters=%h want 0 1 %h", early, clusters_valid, clusters, sa);
        end
        total++;
        if (frame_overrun !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b flags got ovr=%b busy=%b want 0 1", frame_overrun, busy); end
        step();
        expect_frame("b2b second", vb, 2);
    endtask

    task automatic test_bad_adr();
        logic [NP-1:0] v;
        v = '0;
        v[3] = 1'b1;
        bad_adr = 1'b1;
        start(v);
        check_frame("bad adr", {NC{3'd7, 11'h7F0}}, 2 + NC * (LAT + 2), v, 1);
        bad_adr = 1'b0;
    endtask

    task automatic test_pass_echo();
        logic [NP-1:0] v;
        v = '0;
        v[10] = 1'b1; v[20] = 1'b1; v[30] = 1'b1;
        corrupt = 1'b1;
        start(v);
`ifdef PASS_CHECK_EN
        begin
            logic [SW-1:0] s;
            logic [NP-1:0] left;
            s = ALL_INV;
            s[13:0] = {cnt_of(11'd10), 11'd10};
            left = v;
            left[10] = 1'b0;
            check_frame("pass echo", s, 2 + 2 * (LAT + 2), left, 1);
            total++;
            if (pass_err !== 1'b1) begin bad++; $display("FAIL pass echo err got=%b want=1", pass_err); end
        end
`else
        expect_frame("pass echo", v, 1);
        total++;
        if (pass_err !== 1'b0) begin bad++; $display("FAIL pass echo err got=%b want=0", pass_err); end
`endif
        corrupt = 1'b0;
    endtask

    task automatic test_overrun();
        logic [NP-1:0] va, vb;
        logic early;
        va = '0;
        for (int i = 0; i < 10; i++) va[40 * i + 7] = 1'b1;
        vb = rand_mask(4);
        start(va);
        early = 1'b0;
        repeat (17) begin step(); early |= clusters_valid; end
        total++;
        if (enc_pass !== 3'd3) begin bad++; $display("FAIL overrun pass tag got=%0d want=3", enc_pass); end
        start(vb);
        total++;
        if (early || frame_overrun !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL overrun flags got early=%b ovr=%b busy=%b want 0 1 1", early, frame_overrun, busy);
        end
        expect_frame("overrun new", vb, 1);
    endtask

    task automatic test_async_reset();
        logic early;
        start(rand_mask(10));
        repeat (10) step();
        #3 rst_n = 1'b0;
        #1;
        total++;
        if ({busy, clusters_valid, enc_latch_pulse, frame_overrun, pass_err} !== 5'b0) begin
            bad++;
            $display("FAIL async flags got=%b want=00000", {busy, clusters_valid, enc_latch_pulse, frame_overrun, pass_err});
        end
        total++;
        if (clusters !== ALL_INV || enc_vpfs !== '0 || enc_pass !== 3'd0) begin
            bad++;
            $display("FAIL async data got clusters=%h pass=%0d want=%h 0", clusters, enc_pass, ALL_INV);
        end
        step();
        rst_n = 1'b1;
        early = 1'b0;
        repeat (60) begin step(); early |= clusters_valid; end
        total++;
        if (early || busy !== 1'b0) begin bad++; $display("FAIL async idle got valid_seen=%b busy=%b want 0 0", early, busy); end
        begin
            logic [NP-1:0] v;
            v = rand_mask(5);
            start(v);
            expect_frame("after reset", v, 1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_ten();
        test_empty();
        test_random();
        test_back_to_back();
        test_bad_adr();
        test_pass_echo();
        test_overrun();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
